fib_stream_gen: RTL and testbench
=================================

Name: fib_stream_gen

Overview:
- Parametrised successor to the two-register sequence generator: produces a generalised Fibonacci sequence a(n+1)=b, b(n+1)=a+b as a valid/ready stream.
- Adds runtime seeds, a programmable term count, an overflow policy (wrap / saturate / halt) and a running term index.
- Sits behind a control master (start/len/seeds) and feeds a downstream consumer that may stall.

Parameters:
- WIDTH, 8, datapath width of a, b and out_data.
- CNT_W, 8, width of len and term_idx.
- RST_A, 0, value of a after reset.
- RST_B, 1, value of b after reset.
- OVF_MODE, 0, overflow policy: 0 = wrap modulo 2^WIDTH, 1 = saturate to all-ones, 2 = halt.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle request to load seeds and begin a run; honoured only in IDLE or DONE.
- seed_a  in  WIDTH  first term, sampled on an accepted start.
- seed_b  in  WIDTH  second term, sampled on an accepted start.
- len  in  CNT_W  number of terms to emit, sampled on an accepted start; 0 means free-running.
- out_valid  out  1  out_data holds a term.
- out_ready  in  1  consumer accepts the term this cycle.
- out_data  out  WIDTH  current term (register a).
- term_idx  out  CNT_W  index of the current term; 0 for the first term; wraps modulo 2^CNT_W.
- overflow  out  1  sticky; set when any a+b carried out of WIDTH bits during the run.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; a=RST_A; b=RST_B; term_idx=0; overflow=0; out_valid=0; busy=0; done=0. Deassertion is used synchronously.
- IDLE: out_valid=0. An accepted start loads a=seed_a, b=seed_b, rem=len, term_idx=0 and overflow=0, then moves to RUN. out_valid goes high the next cycle, so latency from start to first term is 1 cycle.
- RUN: out_valid=1 and out_data=a.
  - A beat fires when out_valid and out_ready are both high.
  - On a beat: a<=b; b<=f(a+b); term_idx<=term_idx+1.
  - If rem!=0, rem decrements; when a beat consumes the last term (rem==1), go to DONE.
  - A stall (out_ready=0) holds a, b, term_idx and rem. out_data stays stable while out_valid is high.
- Sum arithmetic: computed at WIDTH+1 bits; carry = bit WIDTH. f() applies the policy:
  - wrap: keep the low WIDTH bits.
  - saturate: all-ones if carry is set.
  - halt: on a beat whose sum carries, the current term is still delivered, overflow is set and the state goes to DONE with no further terms.
  - overflow is set on any carry in every mode.
  - In saturate mode, once b is saturated, later sums stay all-ones and keep re-setting overflow (the flag is sticky, so there is no visible change).
- DONE: out_valid=0; busy=0; done=1 for the entry cycle only. a, b, term_idx and overflow are held for readout. start restarts as from IDLE.
- start during RUN is ignored, with no side effects.
- start and the final beat in the same cycle: the beat completes and the state goes to DONE. start is ignored that cycle.
- len=0: runs until reset; term_idx wraps silently.
- Reset mid-run: the stream aborts immediately and out_valid drops asynchronously.
- out_ready is don't-care while out_valid=0.

Test Plan:
- Reset, then start with seed 0/1, len=14, out_ready=1 constantly (WIDTH=8, OVF_MODE=0) -> out_data 0,1,1,2,3,5,8,13,21,34,55,89,144,233 on term_idx 0..13; done pulses once; overflow=0.
- Same start with len=16 in wrap mode -> terms 13,14,15 = 233,121,98 (377 mod 256, 610 mod 256); overflow=1 once the 377 sum is computed (during the beat delivering 144).
- OVF_MODE=1, len=16 -> terms 13..15 = 233,255,255; overflow=1.
- OVF_MODE=2, len=0 -> last term delivered is 144 at idx 12 (its beat computes 377), then DONE with overflow=1; 233 is never emitted.
- Seed 2/1 (Lucas), len=5, out_ready toggled 1,0,0,1,... -> terms 2,1,3,4,7; each term held across stalls; term_idx advances only on beats.
- Assert rst low mid-run after term 5 -> out_valid=0 immediately; a/b return to RST_A/RST_B; a new start restarts cleanly from the new seeds.

Source files
------------

// File: rtl/fib_stream_gen.sv
// Generalised Fibonacci stream generator: emits a, with a<=b and b<=f(a+b) on each
// accepted beat. Supports runtime seeds, a term count and a wrap/saturate/halt overflow policy.
module fib_stream_gen #(
  parameter int              WIDTH    = 8,
  parameter int              CNT_W    = 8,
  parameter logic [WIDTH-1:0] RST_A   = '0,
  parameter logic [WIDTH-1:0] RST_B   = WIDTH'(1),
  parameter int              OVF_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] term_idx,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a term transfers on every rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready is low, out_data and term_idx are held.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a, b, b_next;
  logic [CNT_W-1:0] rem;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             beat;
  logic             accept;
  logic             last;
  logic             done_r;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    carry  = sum[WIDTH];
    b_next = sum[WIDTH-1:0];
    if (OVF_MODE == 1 && carry) b_next = '1;
    beat   = (state == S_RUN) && out_ready;
    accept = start && (state != S_RUN);
    // In halt mode a carrying beat is the final one regardless of rem.
    last   = beat && ((rem == CNT_W'(1)) || (OVF_MODE == 2 && carry));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (last) state_next = S_DONE;
      S_DONE:  if (accept) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a        <= RST_A;
      b        <= RST_B;
      rem      <= '0;
      term_idx <= '0;
      overflow <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state != S_DONE) && (state_next == S_DONE);
      if (accept) begin
        a        <= seed_a;
        b        <= seed_b;
        rem      <= len;
        term_idx <= '0;
        overflow <= 1'b0;
      end else if (beat) begin
        a        <= b;
        b        <= b_next;
        term_idx <= term_idx + CNT_W'(1);
        if (carry) overflow <= 1'b1;
        // rem == 0 means free-running, so it never counts down.
        if (rem != '0) rem <= rem - CNT_W'(1);
      end
    end
  end

  assign out_valid = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign out_data  = a;
  assign done      = done_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Bench for fib_stream_gen: three instances (wrap, saturate, halt) share stimulus and
// are compared against an arithmetic sequence model per overflow policy.
module tb_fib_stream_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] seed_a, seed_b, len;
  logic       out_ready;
  logic [2:0] valid, ovf, busy, done;
  logic [7:0] data [3];
  logic [7:0] idx [3];
  logic [1:0] dbg [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q0[$], exp_q1[$], exp_q2[$], mq[$];
  bit  mov;
  bit  strict [3];
  bit  mov_exp [3];
  int  exp_idx [3];
  int  done_cnt [3];
  int  nterms [3];

  fib_stream_gen #(.WIDTH(8), .CNT_W(8), .OVF_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b), .len(len),
    .out_valid(valid[0]), .out_ready(out_ready), .out_data(data[0]), .term_idx(idx[0]),
    .overflow(ovf[0]), .busy(busy[0]), .done(done[0]), .state_dbg(dbg[0]));

  fib_stream_gen #(.WIDTH(8), .CNT_W(8), .OVF_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b), .len(len),
    .out_valid(valid[1]), .out_ready(out_ready), .out_data(data[1]), .term_idx(idx[1]),
    .overflow(ovf[1]), .busy(busy[1]), .done(done[1]), .state_dbg(dbg[1]));

  fib_stream_gen #(.WIDTH(8), .CNT_W(8), .OVF_MODE(2)) u_halt (
    .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b), .len(len),
    .out_valid(valid[2]), .out_ready(out_ready), .out_data(data[2]), .term_idx(idx[2]),
    .overflow(ovf[2]), .busy(busy[2]), .done(done[2]), .state_dbg(dbg[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: list of terms the consumer should see for one run under a given policy.
  task automatic model(input int mode, input int sa, input int sb, input int ln, input int cap);
    int x, y, s, n, nx;
    mq.delete();
    mov = 0;
    x = sa;
    y = sb;
    n = 0;
    forever begin
      mq.push_back(8'(x));
      n++;
      s = x + y;
      if (s > 255) mov = 1;
      if (mode == 2 && s > 255) break;
      if (ln != 0 && n == ln) break;
      if (ln == 0 && n == cap) break;
      nx = y;
      y  = (mode == 1 && s > 255) ? 255 : s % 256;
      x  = nx;
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qfront(input int i);
    case (i)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    case (i)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  // driver: one run with ready pattern rmode (0 always, 1 every third cycle, 2 random)
  task automatic run(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] ln,
                     input int rmode, input bit mid_start);
    int  cyc;
    bit  complete;
    for (int m = 0; m < 3; m++) begin
      model(m, int'(sa), int'(sb), int'(ln), 24);
      case (m)
        0:       exp_q0 = mq;
        1:       exp_q1 = mq;
        default: exp_q2 = mq;
      endcase
      mov_exp[m]  = mov;
      nterms[m]   = mq.size();
      strict[m]   = (ln != 0) || (m == 2);
      exp_idx[m]  = 0;
      done_cnt[m] = 0;
    end
    @(negedge clk);
    start = 1'b1; seed_a = sa; seed_b = sb; len = ln; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("first_valid", 32'(valid[i]), 32'd1);
      check("first_data", 32'(data[i]), 32'(qfront(i)));
      check("first_idx", 32'(idx[i]), 32'd0);
    end
    cyc = 0;
    while (cyc < 400) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mid_start && cyc == 3) begin
        start = 1'b1; seed_a = 8'd99; seed_b = 8'd7; len = 8'd2;
      end else begin
        start = 1'b0;
      end
      #1;
      complete = 1'b1;
      for (int i = 0; i < 3; i++) begin
        done_cnt[i] += int'(done[i]);
        if (qsize(i) != 0 || (strict[i] && busy[i])) complete = 1'b0;
      end
      if (complete) break;
      for (int i = 0; i < 3; i++) begin
        if (valid[i]) begin
          if (qsize(i) > 0) begin
            check("term_data", 32'(data[i]), 32'(qfront(i)));
            if (out_ready) begin
              check("term_idx", 32'(idx[i]), 32'(exp_idx[i] % 256));
              qpop(i);
              exp_idx[i]++;
            end
          end else if (strict[i]) begin
            check("extra_term", 32'(valid[i]), 32'd0);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("run_timeout", 32'(cyc < 400), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (strict[i]) begin
        check("done_pulses", 32'(done_cnt[i]), 32'd1);
        check("end_overflow", 32'(ovf[i]), 32'(mov_exp[i]));
        check("end_busy", 32'(busy[i]), 32'd0);
        check("end_valid", 32'(valid[i]), 32'd0);
        check("end_idx", 32'(idx[i]), 32'(nterms[i] % 256));
      end
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (strict[i]) check("done_one_cycle", 32'(done[i]), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_valid"}, 32'(valid[i]), 32'd0);
      check({tag, "_busy"}, 32'(busy[i]), 32'd0);
      check({tag, "_done"}, 32'(done[i]), 32'd0);
      check({tag, "_ovf"}, 32'(ovf[i]), 32'd0);
      check({tag, "_idx"}, 32'(idx[i]), 32'd0);
      check({tag, "_data"}, 32'(data[i]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; seed_a = '0; seed_b = '0; len = '0; out_ready = 1'b0;
    #1;
    check_reset_state("reset");
    #20;
    @(negedge clk);
    rst = 1'b1;

    // classic sequence, with a start pulse during RUN that must be ignored
    run(8'd0, 8'd1, 8'd14, 0, 1'b1);
    // restart from DONE, longer run crosses the carry
    run(8'd0, 8'd1, 8'd16, 0, 1'b0);
    // Lucas seeds with stalls
    run(8'd2, 8'd1, 8'd5, 1, 1'b0);
    // free-running: halt instance stops at the first carry
    run(8'd0, 8'd1, 8'd0, 2, 1'b0);

    // asynchronous reset mid-run, away from any clock edge
    @(negedge clk);
    start = 1'b1; seed_a = 8'd2; seed_b = 8'd1; len = 8'd0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    run(8'd5, 8'd8, 8'd10, 2, 1'b0);

    // randomized runs
    for (int k = 0; k < 6; k++)
      run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          8'($urandom_range(1, 12)), 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
